instr_decode_frontend: RTL
==========================

// Module: instr_decode_frontend
// PURPOSE
//  Feeds the multicycle control FSM with its inputs: instruction register (IR), one-hot opcode + RX/RY bus
//  (opcode_out[26:0]) and the flags register. Also owns the run/single-step controller that drives the FSM's run input.
//  Sits between instruction memory / ALU and the control FSM; its IR/flags strobes are control bits the FSM produces.
// PARAMETERS
//  IW      16  instruction width ([15:12] opcode, [11:10] RX, [9:8] RY, [7:0] imm/addr)
//  OPC_W   23  one-hot opcode width
//  FLAG_W  4   flags width ([0] Z, [1] N, [2] O, [3] C)
//  CNT_W   16  retired-instruction counter width
// PORTS
//  clock        in   1       system clock
//  reset        in   1       synchronous, active-high
//  instr_in     in   IW      instruction memory read data
//  ir_load      in   1       IR strobe (control bit c[16], IF state)
//  alu_flags    in   FLAG_W  ALU flag outputs
//  flags_load   in   1       flags strobe (control bit c[21])
//  run_mode     in   1       1 = free run, 0 = single-step
//  step_btn     in   1       raw asynchronous step button
//  run          out  1       run/advance enable to control FSM (top gates FSM state update and ir_load with it)
//  opcode_out   out  27      [22:0] one-hot opcode, [26:25] RX, [24:23] RY
//  flags_reg    out  FLAG_W  registered flags
//  imm_out      out  8       IR[7:0]
//  instr_count  out  CNT_W   instructions fetched since reset
// BEHAVIOUR
//  Reset: IR=0 (NOOP, so opcode_out=27'h1), flags_reg=0, instr_count=0, step FSM=HOLD, sync/edge flops=0.
//  IR: IR<=instr_in on clock where ir_load&run; opcode_out/imm_out combinational from IR (valid 1 cycle after load).
//  Decode IR[15:12]: 0 NOOP->b0; 1 INPUT*->b1+IR[9:8] (C,CF,D,DF); 2 MOVE->b5; 3 LOADI/LOADP->b6; 4 ADD->b7;
//   5 ADDI->b8; 6 SUB->b9; 7 SUBI->b10; 8 LOAD->b11; 9 LOADF->b12; A STORE->b13; B STOREF->b14;
//   C SHIFT->IR[8]?b16(SHIFTR):b15(SHIFTL); D CMP->b17; E JUMP->b18; F branch->b19+IR[9:8] (BRE,BRNE,BRG,BRGE).
//  Exactly one of bits [22:0] high for every IR value (no illegal opcode). RX=IR[11:10], RY=IR[9:8] always.
//  Flags: flags_reg<=alu_flags when flags_load; else hold. Not gated by run.
//  instr_count: +1 on each ir_load&run; wraps 2^CNT_W-1 -> 0.
//  step_btn: 2-flop synchronizer, rising-edge detect -> 1-cycle step_pulse (3-cycle latency from pin).
//  Step FSM:
//   HOLD: run=0. run_mode=1 -> RUN; step_pulse -> ARM.
//   RUN : run=1. run_mode=0 -> EXEC (finish current instruction, stop at next fetch).
//   ARM : run=1. ir_load -> EXEC (instruction fetched).
//   EXEC: run=~ir_load (Mealy); ir_load -> HOLD, so next IF is blocked and not counted.
//  step_pulse outside HOLD ignored. run_mode=1 in ARM/EXEC -> RUN next cycle.
//  Mid-operation reset: all state to reset values next edge; run=0 that cycle's output reflects HOLD after edge.
//  ir_load and flags_load same cycle: both take effect independently.
// STRUCTURE
//  Package i281_pkg: opcode nibble constants, one-hot bit index localparams (NOOP=0..BRGE=22), flag bit
//   indices (FLG_Z=0,FLG_N=1,FLG_O=2,FLG_C=3), step-FSM state enum.
//  Sub-module: i281_opcode_onehot (pure combinational IR->opcode_out decode), reused by the single-cycle core.
// TESTING
//  Decode sweep: load all 16 nibbles x 4 RY values -> one-hot matches table, e.g. 16'hF2xx -> bit21 (BRG), RX=0,RY=2.
//  Flags: alu_flags=4'b0011 + flags_load -> flags_reg=4'b0011 next cycle; held when flags_load=0 with alu_flags changing.
//  Single-step: run_mode=0, step_btn pulse -> run=1 from 3 cycles later; one ir_load -> later ir_load sees run=0, count=1.
//  Free run: run_mode=1, 10 ir_load pulses -> instr_count=10; drop run_mode -> stops at next ir_load, IR unchanged.
//  Wrap: force count to 16'hFFFF, one ir_load&run -> instr_count=0.
//  Reset mid-EXEC: assert reset -> run=0, opcode_out=27'h1, flags_reg=0, count=0 next edge; step ignored while reset high.

Source files
------------

// File: rtl/i281_pkg.sv
// rtl/i281_pkg.sv - opcode nibbles, one-hot bit indices, flag indices and step-FSM states
package i281_pkg;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_INPUT  = 4'h1;
  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [3:0] OP_LOADI  = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SUBI   = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_LOADF  = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_STOREF = 4'hB;
  localparam logic [3:0] OP_SHIFT  = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;

  localparam int B_NOOP    = 0;
  localparam int B_INPUTC  = 1;
  localparam int B_INPUTCF = 2;
  localparam int B_INPUTD  = 3;
  localparam int B_INPUTDF = 4;
  localparam int B_MOVE    = 5;
  localparam int B_LOADI   = 6;
  localparam int B_ADD     = 7;
  localparam int B_ADDI    = 8;
  localparam int B_SUB     = 9;
  localparam int B_SUBI    = 10;
  localparam int B_LOAD    = 11;
  localparam int B_LOADF   = 12;
  localparam int B_STORE   = 13;
  localparam int B_STOREF  = 14;
  localparam int B_SHIFTL  = 15;
  localparam int B_SHIFTR  = 16;
  localparam int B_CMP     = 17;
  localparam int B_JUMP    = 18;
  localparam int B_BRE     = 19;
  localparam int B_BRNE    = 20;
  localparam int B_BRG     = 21;
  localparam int B_BRGE    = 22;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_O = 2;
  localparam int FLG_C = 3;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ARM  = 2'd2,
    ST_EXEC = 2'd3
  } step_state_t;

endpackage

// File: rtl/i281_opcode_onehot.sv
// rtl/i281_opcode_onehot.sv - combinational IR to one-hot opcode plus RX/RY decode
module i281_opcode_onehot
  import i281_pkg::*;
#(
  parameter int OPC_W = 23
) (
  input  logic [15:0]      ir,
  output logic [OPC_W+3:0] opcode_out
);

  int               idx;
  logic [OPC_W-1:0] onehot;

  // Sub-encoded groups (INPUT, SHIFT, branch) pick their member from IR[9:8] or IR[8].
  always_comb begin
    idx = B_NOOP;
    case (ir[15:12])
      OP_NOOP:   idx = B_NOOP;
      OP_INPUT:  idx = B_INPUTC + int'(ir[9:8]);
      OP_MOVE:   idx = B_MOVE;
      OP_LOADI:  idx = B_LOADI;
      OP_ADD:    idx = B_ADD;
      OP_ADDI:   idx = B_ADDI;
      OP_SUB:    idx = B_SUB;
      OP_SUBI:   idx = B_SUBI;
      OP_LOAD:   idx = B_LOAD;
      OP_LOADF:  idx = B_LOADF;
      OP_STORE:  idx = B_STORE;
      OP_STOREF: idx = B_STOREF;
      OP_SHIFT:  idx = ir[8] ? B_SHIFTR : B_SHIFTL;
      OP_CMP:    idx = B_CMP;
      OP_JUMP:   idx = B_JUMP;
      OP_BRANCH: idx = B_BRE + int'(ir[9:8]);
      default:   idx = B_NOOP;
    endcase
    onehot = {{(OPC_W-1){1'b0}}, 1'b1} << idx;
  end

  assign opcode_out = {ir[11:10], ir[9:8], onehot};

endmodule

// File: rtl/instr_decode_frontend.sv
// rtl/instr_decode_frontend.sv - IR, flags, retired counter and run/single-step controller
module instr_decode_frontend
  import i281_pkg::*;
#(
  parameter int IW     = 16,
  parameter int OPC_W  = 23,
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IW-1:0]     instr_in,
  input  logic              ir_load,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              flags_load,
  input  logic              run_mode,
  input  logic              step_btn,
  output logic              run,
  output logic [OPC_W+3:0]  opcode_out,
  output logic [FLAG_W-1:0] flags_reg,
  output logic [7:0]        imm_out,
  output logic [CNT_W-1:0]  instr_count
);

  logic [IW-1:0] ir_q;
  logic          btn_s1, btn_s2, btn_s3;
  logic          step_pulse;
  logic          fetch;
  step_state_t   state_q, state_d;

  assign step_pulse = btn_s2 & ~btn_s3;
  assign fetch      = ir_load & run;

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q        <= '0;
      flags_reg   <= '0;
      instr_count <= '0;
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_s3      <= 1'b0;
      state_q     <= ST_HOLD;
    end else begin
      btn_s1  <= step_btn;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      state_q <= state_d;
      if (fetch) begin
        ir_q        <= instr_in;
        instr_count <= instr_count + 1'b1;
      end
      if (flags_load) begin
        flags_reg <= alu_flags;
      end
    end
  end

  // EXEC lets the current instruction finish, then blocks the very next fetch in its own cycle.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (run_mode)        state_d = ST_RUN;
        else if (step_pulse) state_d = ST_ARM;
      end
      ST_RUN: begin
        run = 1'b1;
        if (!run_mode) state_d = ST_EXEC;
      end
      ST_ARM: begin
        run = 1'b1;
        if (run_mode)     state_d = ST_RUN;
        else if (ir_load) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        run = ~ir_load;
        if (run_mode)     state_d = ST_RUN;
        else if (ir_load) state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  i281_opcode_onehot #(
    .OPC_W(OPC_W)
  ) u_decode (
    .ir         (ir_q[15:0]),
    .opcode_out (opcode_out)
  );

  assign imm_out = ir_q[7:0];

endmodule
